// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampled UART receiver.
// rx is brought into the clk domain through a two-flop synchroniser.
// The start bit is re-checked at its midpoint, which rejects short glitches.
// Data bits are then sampled at each bit centre, LSB first.
// An optional parity bit and the stop bit are checked after the data.
// Each completed frame produces a one-clk rx_done_tick.
// dout, parity_err and frame_err update on the edge that raises the pulse, then hold.
module uart_rx_os16 #(
  parameter int DBIT    = 8,   // data bits per frame, 5..9
  parameter int SB_TICK = 16,  // oversample ticks in the stop bit
  parameter int PARITY  = 0    // 0 none, 1 even, 2 odd
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err,
  output logic            busy
);

  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    BRK   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            perr_pend_q, perr_pend_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;
  logic            rx_meta_q, rx_s_q;

  // Two-flop synchroniser.
  // It resets to the idle (high) level, so coming out of reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame state machine: next state, counters, shift register and output loads.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    dout_d      = dout_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    done_d      = 1'b0;
    unique case (state_q)
      // Start detection runs every clk, not only on ticks.
      // This lets a back-to-back start bit be caught immediately.
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      // Re-sample at the middle of the start bit.
      // A line that is already high again was a glitch.
      START: begin
        if (s_tick) begin
          if (s_q == SW'(7)) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            s_d     = '0;
            shift_d = {rx_s_q, shift_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
              state_d = (PARITY != 0) ? PAR : STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      // The parity verdict is held in perr_pend until STOP.
      // That way all outputs publish together on the done edge.
      PAR: begin
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            s_d         = '0;
            perr_pend_d = (PARITY == 2) ? ~^{shift_q, rx_s_q} : ^{shift_q, rx_s_q};
            state_d     = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            s_d     = '0;
            dout_d  = shift_q;
            perr_d  = (PARITY != 0) ? perr_pend_q : 1'b0;
            ferr_d  = ~rx_s_q;
            done_d  = 1'b1;
            state_d = rx_s_q ? IDLE : BRK;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      // A held-low line (break) must release before another start can be seen.
      BRK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      dout_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
      dout_q      <= dout_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      done_q      <= done_d;
    end
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign busy         = (state_q != IDLE);

endmodule
